// File: rtl/div_pkg.sv
// Shared definitions for the divider slice.
//   DIV_WIDTH   : default operand/result width in bits
//   div_op_e    : operation encoding (RV32M DIV/DIVU/REM/REMU)
//   div_state_e : control FSM states
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem          : current partial remainder
//   dividend_bit : next dividend bit, shifted into the remainder LSB
//   divisor      : divisor magnitude
//   rem_next     : remainder after the trial subtraction
//   quot_bit     : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder needs WIDTH+1 bits; the MSB of the difference is
  // the borrow, so a clear MSB means the trial subtraction succeeded.
  // When it fails the shifted value is below the divisor and fits in WIDTH bits.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[WIDTH];
    rem_next = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; the result appears WIDTH edges after
// the request is accepted, as a single-cycle o_valid pulse.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_valid/o_ready: request handshake (o_ready high only when idle)
//   i_op, i_a, i_b : operation, dividend, divisor
//   i_flush        : abort the in-flight operation
//   o_valid        : one-cycle result strobe
//   o_result       : quotient or remainder
// Configuration macro:
//   DIV_EARLY_OUT_EN : divide-by-zero and signed-overflow requests skip the
//                      iterative phase and complete in the cycle after acceptance.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state;
  div_op_e          op;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] count;
  logic             neg_quot;
  logic             neg_rem;

  logic             is_signed;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             req_neg_quot;
  logic             req_neg_rem;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] final_quot;
  logic [WIDTH-1:0] final_result;

  // Request decode: operand magnitudes and the sign fix-ups to apply at the end.
  // A zero divisor never negates the quotient so that DIV by zero yields -1.
  always_comb begin
    is_signed    = ~i_op[0];
    abs_a        = (is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    abs_b        = (is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    req_neg_quot = is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]) && (i_b != '0);
    req_neg_rem  = is_signed && i_a[WIDTH-1];
  end

`ifdef DIV_EARLY_OUT_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] early_result;

  // Results for the cases that do not need the iterative loop.
  always_comb begin
    div_zero = (i_b == '0);
    overflow = is_signed && (i_a == MIN_NEG) && (i_b == '1);
    if (div_zero) begin
      early_result = i_op[1] ? i_a : '1;
    end else begin
      early_result = i_op[1] ? '0 : MIN_NEG;
    end
  end
`endif

  // The dividend is preloaded into the quotient register: each step shifts one
  // dividend bit out of the top and one quotient bit in at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_q),
    .dividend_bit (quot_q[WIDTH-1]),
    .divisor      (divisor_q),
    .rem_next     (step_rem),
    .quot_bit     (step_bit)
  );

  // Final result uses the values the last step is about to produce, so it can
  // be registered on the same edge that enters DONE.
  always_comb begin
    final_quot = {quot_q[WIDTH-2:0], step_bit};
    if (op == REM || op == REMU) begin
      final_result = neg_rem ? -step_rem : step_rem;
    end else begin
      final_result = neg_quot ? -final_quot : final_quot;
    end
  end

  // Control FSM with registered handshake outputs. Reset and flush both drop
  // the operation; flush takes priority over a new request in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      op        <= DIVU;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      count     <= '0;
      neg_quot  <= 1'b0;
      neg_rem   <= 1'b0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_valid && !i_flush) begin
            op        <= div_op_e'(i_op);
            rem_q     <= '0;
            quot_q    <= abs_a;
            divisor_q <= abs_b;
            count     <= '0;
            neg_quot  <= req_neg_quot;
            neg_rem   <= req_neg_rem;
            o_ready   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            if (div_zero || overflow) begin
              state    <= DONE;
              o_valid  <= 1'b1;
              o_result <= early_result;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end

        CALC: begin
          if (i_flush) begin
            state   <= IDLE;
            count   <= '0;
            o_ready <= 1'b1;
          end else begin
            rem_q  <= step_rem;
            quot_q <= final_quot;
            if (count == LAST_STEP) begin
              state    <= DONE;
              count    <= '0;
              o_valid  <= 1'b1;
              o_result <= final_result;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        // DONE lasts exactly one cycle; a flush here leads to the same place.
        DONE: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit. Latency is counted as the number of clock
// edges after the acceptance edge until o_valid is seen high.
module tb_div_unit;
  import div_pkg::*;

  localparam int W = 32;
  localparam int TIMEOUT = 40;
  localparam int LAT_NORMAL = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 0;
`else
  localparam int LAT_SPECIAL = 32;
`endif

  logic         i_clk;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [1:0]   i_op;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_flush;
  logic         o_valid;
  logic [W-1:0] o_result;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(W)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Present a request for one edge; returns #1 after the acceptance edge.
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  // Bounded wait for o_valid; lat = -1 when it never shows up.
  task automatic wait_valid(output int lat);
    bit found;
    found = 1'b0;
    lat = -1;
    if (o_valid === 1'b1) begin
      lat = 0;
      found = 1'b1;
    end
    for (int i = 1; i <= TIMEOUT && !found; i++) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) begin
        lat = i;
        found = 1'b1;
      end
    end
  endtask

  // Count o_valid pulses over a window of cycles.
  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge i_clk);
      #1;
      if (o_valid === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b expected 1", o_ready);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid got %b expected 0", o_valid);
    end
    checks++;
    if (o_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_result got %h expected 00000000", o_result);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    start_op(2'b01, 32'd100, 32'd7);
    checks++;
    if (o_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_ready got %b expected 0", o_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== LAT_NORMAL) begin
      errors++;
      $display("[TB] FAIL divu_latency got %0d expected %0d", lat, LAT_NORMAL);
    end
    checks++;
    if (o_result !== 32'd14) begin
      errors++;
      $display("[TB] FAIL divu_100_7 got %h expected 0000000e", o_result);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pulse_end got valid=%b ready=%b expected valid=0 ready=1", o_valid, o_ready);
    end

    start_op(2'b11, 32'd100, 32'd7);
    wait_valid(lat);
    checks++;
    if (lat !== LAT_NORMAL || o_result !== 32'd2) begin
      errors++;
      $display("[TB] FAIL remu_100_7 got %h lat %0d expected 00000002 lat %0d", o_result, lat, LAT_NORMAL);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_signed();
    logic [1:0]   ops  [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
    logic [W-1:0] as   [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7};
    logic [W-1:0] bs   [4] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [W-1:0] exps [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFD};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_valid(lat);
      checks++;
      if (lat !== LAT_NORMAL || o_result !== exps[i]) begin
        errors++;
        $display("[TB] FAIL signed_%0d got %h lat %0d expected %h lat %0d", i, o_result, lat, exps[i], LAT_NORMAL);
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    logic [1:0]   ops  [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    logic [W-1:0] as   [4] = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [W-1:0] exps [4] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], 32'd0);
      wait_valid(lat);
      checks++;
      if (lat !== LAT_SPECIAL || o_result !== exps[i]) begin
        errors++;
        $display("[TB] FAIL divzero_%0d got %h lat %0d expected %h lat %0d", i, o_result, lat, exps[i], LAT_SPECIAL);
      end
      @(posedge i_clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL divzero_pulse_%0d got valid=%b ready=%b expected valid=0 ready=1", i, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(2'b00, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(lat);
    checks++;
    if (lat !== LAT_SPECIAL || o_result !== 32'h80000000) begin
      errors++;
      $display("[TB] FAIL ovf_div got %h lat %0d expected 80000000 lat %0d", o_result, lat, LAT_SPECIAL);
    end
    @(posedge i_clk);
    #1;
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_valid(lat);
    checks++;
    if (lat !== LAT_SPECIAL || o_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL ovf_rem got %h lat %0d expected 00000000 lat %0d", o_result, lat, LAT_SPECIAL);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_flush();
    int lat;
    int pulses;
    // Flush on the 10th step edge.
    start_op(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge i_clk);
    #1;
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle got ready=%b valid=%b expected ready=1 valid=0", o_ready, o_valid);
    end
    count_pulses(TIMEOUT, pulses);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL flush_no_valid got %0d pulses expected 0", pulses);
    end

    // Flush together with a request in IDLE must not start anything.
    i_flush = 1'b1;
    start_op(2'b01, 32'd50, 32'd5);
    i_flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_priority got ready=%b expected 1", o_ready);
    end

    start_op(2'b01, 32'd9, 32'd3);
    wait_valid(lat);
    checks++;
    if (lat !== LAT_NORMAL || o_result !== 32'd3) begin
      errors++;
      $display("[TB] FAIL after_flush got %h lat %0d expected 00000003 lat %0d", o_result, lat, LAT_NORMAL);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int pulses;
    // o_result currently holds 3 from the previous operation.
    start_op(2'b01, 32'd100, 32'd7);
    repeat (19) @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid got ready=%b valid=%b result=%h expected 1 0 00000000", o_ready, o_valid, o_result);
    end
    count_pulses(TIMEOUT, pulses);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_valid got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int pulses;
    start_op(2'b01, 32'd100, 32'd7);
    // Keep a different request pending while busy; it must be ignored.
    i_op    = 2'b01;
    i_a     = 32'd50;
    i_b     = 32'd5;
    i_valid = 1'b1;
    wait_valid(lat);
    i_valid = 1'b0;
    checks++;
    if (lat !== LAT_NORMAL || o_result !== 32'd14) begin
      errors++;
      $display("[TB] FAIL busy_ignore got %h lat %0d expected 0000000e lat %0d", o_result, lat, LAT_NORMAL);
    end
    count_pulses(TIMEOUT, pulses);
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("[TB] FAIL busy_single_pulse got %0d extra pulses expected 0", pulses);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_busy_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_valid  input  1  request valid.
REQ-005 SHALL have port: o_ready  output  1  unit idle, can accept a request.
REQ-006 SHALL have port: i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding).
REQ-007 SHALL have port: i_a  input  WIDTH  dividend.
REQ-008 SHALL have port: i_b  input  WIDTH  divisor.
REQ-009 SHALL have port: i_flush  input  1  abort the in-flight operation.
REQ-010 SHALL have port: o_valid  output  1  result valid, one-cycle pulse.
REQ-011 SHALL have port: o_result  output  WIDTH  quotient or remainder per the latched op.

Function
REQ-012 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-013 SHALL accept a request on an edge where state=IDLE, i_valid=1, i_flush=0, and latch i_op, |i_a|, |i_b| and sign information.
REQ-014 SHALL perform one restoring-division step per cycle in CALC: shift remainder left by one bit, trial-subtract divisor with a (WIDTH+1)-bit subtractor, keep the difference if non-negative and set quotient bit to 1.
REQ-015 SHALL complete exactly WIDTH steps, with o_valid high during the cycle after the WIDTH-th edge following acceptance (32 edges for WIDTH=32).
REQ-016 SHALL, for signed ops, negate the quotient when operand signs differ and give the remainder the sign of the dividend.
REQ-017 SHALL hold o_result stable and o_valid high for exactly one cycle, then return to IDLE with no output back-pressure.
REQ-018 SHALL, for divisor=0, return quotient all-ones (DIVU 0xFFFFFFFF, DIV -1) and remainder = i_a.
REQ-019 SHALL, for DIV/REM with -2^(WIDTH-1) / -1, return quotient -2^(WIDTH-1) and remainder 0.
REQ-020 SHALL, on i_flush=1 in CALC or DONE, go to IDLE on that edge; o_valid is not asserted for the aborted operation after that edge.
REQ-021 SHALL give i_flush priority over acceptance: i_flush=1 with i_valid=1 in IDLE accepts nothing.
REQ-022 SHALL ignore i_valid while state is not IDLE.

Reset
REQ-023 SHALL, on i_reset=1 at a rising edge, enter IDLE from any state, including mid-CALC, and discard the operation.
REQ-024 SHALL reset outputs and state to: o_ready=1, o_valid=0, o_result=0, iteration counter=0, remainder and quotient registers=0.

Configuration
REQ-025 SHALL, with macro DIV_EARLY_OUT_EN defined, send a divide-by-zero or signed-overflow request from IDLE directly to DONE, so that o_valid rises in the cycle after acceptance.
REQ-026 SHALL, without DIV_EARLY_OUT_EN, run those cases through the full WIDTH-step CALC and still produce the REQ-018/019 results.

Structure
REQ-027 SHALL place in shared package div_pkg: the WIDTH default constant, the div_op_e enum (DIV, DIVU, REM, REMU) and the div_state_e enum (IDLE, CALC, DONE).
REQ-028 SHALL contain one sub-module, div_step, which is combinational and takes remainder, next dividend bit and divisor, and returns the next remainder and the quotient bit.

Verification
REQ-029 SHALL verify: DIVU 100/7 -> o_result=14 at the 32nd edge after acceptance; REMU 100/7 -> 2.
REQ-030 SHALL verify: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-031 SHALL verify: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, in 1 cycle with DIV_EARLY_OUT_EN and 32 cycles without it.
REQ-032 SHALL verify: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-033 SHALL verify: i_flush at step 10 -> IDLE on the next cycle with no o_valid; the next request DIVU 9/3 -> 3.
REQ-034 SHALL verify: i_reset at step 20 -> o_ready=1, o_valid=0, o_result=0 next cycle; i_valid asserted while busy -> ignored, single o_valid pulse.
